// File: rtl/sb_trigger_pkg.sv
// Shared types and constants for the large-PMT single-bin threshold trigger.
package sb_trigger_pkg;

    localparam int unsigned ADC_W  = 24;
    localparam int unsigned HG_MSB = 23;
    localparam int unsigned HG_LSB = 12;
    localparam int unsigned HG_W   = HG_MSB - HG_LSB + 1;
    localparam int unsigned NPMT   = 3;
    localparam int unsigned WIN_W  = 4;
    localparam int unsigned DEAD_W = 16;
    localparam int unsigned MULT_W = 2;

    typedef enum logic [1:0] {
        ST_DISARMED,
        ST_ARMED,
        ST_TRIG,
        ST_DEAD
    } trig_state_t;

    // Number of set bits in a three-channel hit vector.
    function automatic logic [MULT_W-1:0] popcount3(input logic [NPMT-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/sb_hit_stretch.sv
// Per-channel strict HG threshold compare followed by a coincidence-window stretcher.
module sb_hit_stretch
    import sb_trigger_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [HG_W-1:0]  hg,
    input  logic [HG_W-1:0]  thresh,
    input  logic [WIN_W-1:0] coinc_win,
    input  logic             clear,
    output logic             hit
);

    logic             above;
    logic [WIN_W-1:0] cnt;

    // Clear wins over a reload so a trigger always starts the next window fresh.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            above <= 1'b0;
            cnt   <= '0;
        end else begin
            above <= (hg > thresh);
            if (clear) begin
                cnt <= '0;
            end else if (above) begin
                cnt <= coinc_win;
            end else if (cnt != '0) begin
                cnt <= cnt - WIN_W'(1);
            end
        end
    end

    assign hit = above | (cnt != '0);

endmodule

// File: rtl/sb_threshold_trigger.sv
// Three-channel threshold trigger: multiplicity over stretched hits, one-cycle TRIG, then dead time.
module sb_threshold_trigger
    import sb_trigger_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic [ADC_W-1:0]   ADC0_IN,
    input  logic [ADC_W-1:0]   ADC1_IN,
    input  logic [ADC_W-1:0]   ADC2_IN,
    input  logic [HG_W-1:0]    THRESH0,
    input  logic [HG_W-1:0]    THRESH1,
    input  logic [HG_W-1:0]    THRESH2,
    input  logic [MULT_W-1:0]  MULTIPLICITY,
    input  logic [WIN_W-1:0]   COINC_WIN,
    input  logic [DEAD_W-1:0]  DEADTIME,
    output logic               TRIG,
    output logic [NPMT-1:0]    TRIG_MASK,
    output logic [COUNT_W-1:0] TRIG_COUNT,
    output logic               BUSY
);

    trig_state_t       state, state_nxt;
    logic [DEAD_W-1:0] dead_cnt;
    logic [NPMT-1:0]   hit;
    logic [HG_W-1:0]   hg     [NPMT];
    logic [HG_W-1:0]   thresh [NPMT];
    logic [MULT_W-1:0] nhit_c;
    logic [MULT_W-1:0] mult_eff_c;
    logic              cond_c;
    logic              clear_c;
    logic              lg_unused;

    assign hg[0]     = ADC0_IN[HG_MSB:HG_LSB];
    assign hg[1]     = ADC1_IN[HG_MSB:HG_LSB];
    assign hg[2]     = ADC2_IN[HG_MSB:HG_LSB];
    assign thresh[0] = THRESH0;
    assign thresh[1] = THRESH1;
    assign thresh[2] = THRESH2;
    assign lg_unused = ^{ADC0_IN[HG_LSB-1:0], ADC1_IN[HG_LSB-1:0], ADC2_IN[HG_LSB-1:0]};

    assign clear_c = (state == ST_TRIG);

    for (genvar i = 0; i < int'(NPMT); i++) begin : g_ch
        sb_hit_stretch u_stretch (
            .CLK       (CLK),
            .RESET     (RESET),
            .hg        (hg[i]),
            .thresh    (thresh[i]),
            .coinc_win (COINC_WIN),
            .clear     (clear_c),
            .hit       (hit[i])
        );
    end

    assign nhit_c     = popcount3(hit);
    assign mult_eff_c = (MULTIPLICITY == '0) ? MULT_W'(1) : MULTIPLICITY;
    assign cond_c     = (nhit_c >= mult_eff_c);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_DISARMED;
        end else begin
            state <= state_nxt;
        end
    end

    // ENABLE low overrides every transition, including the exit from TRIG.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DISARMED: if (ENABLE) state_nxt = ST_ARMED;
            ST_ARMED:    if (cond_c) state_nxt = ST_TRIG;
            ST_TRIG:     state_nxt = (dead_cnt == '0) ? ST_ARMED : ST_DEAD;
            ST_DEAD:     if (dead_cnt <= DEAD_W'(1)) state_nxt = ST_ARMED;
            default:     state_nxt = ST_DISARMED;
        endcase
        if (!ENABLE) begin
            state_nxt = ST_DISARMED;
        end
    end

    // DEADTIME is captured on the edge entering TRIG and counted down only in DEAD.
    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE) begin
            dead_cnt <= '0;
        end else if (state_nxt == ST_TRIG) begin
            dead_cnt <= DEADTIME;
        end else if (state == ST_DEAD && dead_cnt != '0) begin
            dead_cnt <= dead_cnt - DEAD_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            TRIG       <= 1'b0;
            BUSY       <= 1'b0;
            TRIG_MASK  <= '0;
            TRIG_COUNT <= '0;
        end else begin
            TRIG <= (state_nxt == ST_TRIG);
            BUSY <= (state_nxt == ST_TRIG) || (state_nxt == ST_DEAD);
            if (state_nxt == ST_TRIG) begin
                TRIG_MASK <= hit;
                if (TRIG_COUNT != '1) begin
                    TRIG_COUNT <= TRIG_COUNT + COUNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_threshold_trigger.sv
// Directed and randomized checks of sb_threshold_trigger against a cycle-level behavioural model.
module tb_sb_threshold_trigger;

    localparam int unsigned CW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic [23:0]   ADC0_IN, ADC1_IN, ADC2_IN;
    logic [11:0]   THRESH0, THRESH1, THRESH2;
    logic [1:0]    MULTIPLICITY;
    logic [3:0]    COINC_WIN;
    logic [15:0]   DEADTIME;
    logic          TRIG;
    logic [2:0]    TRIG_MASK;
    logic [CW-1:0] TRIG_COUNT;
    logic          BUSY;

    sb_threshold_trigger #(.COUNT_W(CW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .ADC0_IN      (ADC0_IN),
        .ADC1_IN      (ADC1_IN),
        .ADC2_IN      (ADC2_IN),
        .THRESH0      (THRESH0),
        .THRESH1      (THRESH1),
        .THRESH2      (THRESH2),
        .MULTIPLICITY (MULTIPLICITY),
        .COINC_WIN    (COINC_WIN),
        .DEADTIME     (DEADTIME),
        .TRIG         (TRIG),
        .TRIG_MASK    (TRIG_MASK),
        .TRIG_COUNT   (TRIG_COUNT),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int seen_trig = 0;
    int seen_busy = 0;

    // Reference model: hold time per channel, a busy-cycles-remaining count and an armed flag.
    bit       m_above [3];
    int       m_hold  [3];
    bit       m_armed;
    int       m_busy_left;
    bit       m_trig, m_busy;
    bit [2:0] m_mask;
    int       m_count;

    function automatic logic [23:0] mk(input int hg);
        logic [11:0] lg;
        lg = 12'($urandom);
        return {12'(hg), lg};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int hg [3];
        int th [3];
        bit hitv [3];
        int nh;
        int need;
        bit cur_trig;
        hg = '{int'(ADC0_IN[23:12]), int'(ADC1_IN[23:12]), int'(ADC2_IN[23:12])};
        th = '{int'(THRESH0), int'(THRESH1), int'(THRESH2)};
        cur_trig = m_trig;
        nh = 0;
        for (int i = 0; i < 3; i++) begin
            hitv[i] = m_above[i] || (m_hold[i] > 0);
            nh += int'(hitv[i]);
        end
        need = (MULTIPLICITY == 2'd0) ? 1 : int'(MULTIPLICITY);
        if (RESET) begin
            for (int i = 0; i < 3; i++) begin
                m_above[i] = 1'b0;
                m_hold[i]  = 0;
            end
            m_armed = 1'b0; m_busy_left = 0; m_trig = 1'b0; m_busy = 1'b0;
            m_mask = 3'b000; m_count = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (cur_trig)            m_hold[i] = 0;
            else if (m_above[i])     m_hold[i] = int'(COINC_WIN);
            else if (m_hold[i] > 0)  m_hold[i] = m_hold[i] - 1;
            m_above[i] = (hg[i] > th[i]);
        end
        m_trig = 1'b0;
        if (!ENABLE) begin
            m_armed = 1'b0;
            m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left = m_busy_left - 1;
            if (m_busy_left == 0) m_armed = 1'b1;
        end else if (!m_armed) begin
            m_armed = 1'b1;
        end else if (nh >= need) begin
            m_trig = 1'b1;
            m_armed = 1'b0;
            m_busy_left = 1 + int'(DEADTIME);
            m_mask = {hitv[2], hitv[1], hitv[0]};
            if (m_count < (1 << CW) - 1) m_count++;
        end
        m_busy = (m_busy_left > 0);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            model_edge();
            #1;
            chk("trig",  32'(TRIG),       32'(m_trig));
            chk("busy",  32'(BUSY),       32'(m_busy));
            chk("mask",  32'(TRIG_MASK),  32'(m_mask));
            chk("count", 32'(TRIG_COUNT), 32'(m_count));
            if (TRIG) seen_trig++;
            if (BUSY) seen_busy++;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
    endtask

    task automatic wait_trig(input int lim);
        int k;
        k = 0;
        while (!TRIG && k < lim) begin
            step(1);
            k++;
        end
        chk("wait_trig", 32'(TRIG), 32'd1);
    endtask

    task automatic rnd_all();
        ADC0_IN = 24'($urandom); ADC1_IN = 24'($urandom); ADC2_IN = 24'($urandom);
        THRESH0 = 12'($urandom); THRESH1 = 12'($urandom); THRESH2 = 12'($urandom);
        MULTIPLICITY = 2'($urandom); COINC_WIN = 4'($urandom);
        DEADTIME = 16'($urandom_range(0, 6));
    endtask

    function automatic logic [11:0] pick_thresh();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 12'h000;
        if (r == 1) return 12'hFFF;
        return 12'($urandom_range(1000, 3500));
    endfunction

    initial begin
        // Reset with all inputs random.
        RESET = 1'b1; ENABLE = 1'b1;
        rnd_all();
        step(3);
        chk("rst_trig",  32'(TRIG), 32'd0);
        chk("rst_busy",  32'(BUSY), 32'd0);
        chk("rst_mask",  32'(TRIG_MASK), 32'd0);
        chk("rst_count", 32'(TRIG_COUNT), 32'd0);

        // Disarmed: nothing fires even with every channel hitting.
        RESET = 1'b0; ENABLE = 1'b0;
        THRESH0 = 12'd0; THRESH1 = 12'd0; THRESH2 = 12'd0; MULTIPLICITY = 2'd1;
        seen_trig = 0;
        for (int i = 0; i < 10; i++) begin
            ADC0_IN = 24'($urandom); ADC1_IN = 24'($urandom); ADC2_IN = 24'($urandom);
            step(1);
        end
        chk("disabled_no_trig", 32'(seen_trig), 32'd0);

        // Strict threshold, with FFF thresholds on the other channels.
        ENABLE = 1'b1; THRESH0 = 12'd1000; THRESH1 = 12'hFFF; THRESH2 = 12'hFFF;
        MULTIPLICITY = 2'd1; COINC_WIN = 4'd0; DEADTIME = 16'd5;
        ADC0_IN = mk(1000); ADC1_IN = mk(4095); ADC2_IN = mk(4095);
        do_reset();
        step(4);
        seen_trig = 0;
        step(6);
        chk("equal_no_trig", 32'(seen_trig), 32'd0);
        ADC0_IN = mk(1001);
        step(1);
        ADC0_IN = mk(0);
        chk("strict_edge_n", 32'(TRIG), 32'd0);
        step(1);
        chk("strict_trig",  32'(TRIG), 32'd1);
        chk("strict_mask",  32'(TRIG_MASK), 32'b001);
        chk("strict_count", 32'(TRIG_COUNT), 32'd1);
        step(1);
        chk("strict_one_cycle", 32'(TRIG), 32'd0);

        // Coincidence window: second pulse 3 cycles later overlaps, 5 cycles later does not.
        THRESH0 = 12'd500; THRESH1 = 12'd500; THRESH2 = 12'd500;
        MULTIPLICITY = 2'd2; COINC_WIN = 4'd4; DEADTIME = 16'd3;
        ADC0_IN = mk(0); ADC1_IN = mk(0); ADC2_IN = mk(0);
        do_reset();
        step(4);
        for (int b = 3; b <= 5; b += 2) begin
            seen_trig = 0;
            for (int c = 0; c < 13; c++) begin
                ADC0_IN = mk((c == 0) ? 600 : 0);
                ADC1_IN = mk((c == b) ? 600 : 0);
                step(1);
            end
            step(6);
            chk((b == 3) ? "coinc_gap3_trigs" : "coinc_gap5_trigs", 32'(seen_trig), (b == 3) ? 32'd1 : 32'd0);
            chk("coinc_mask", 32'(TRIG_MASK), 32'b011);
        end

        // Dead time: sustained hit retriggers every DEADTIME+2 cycles.
        THRESH0 = 12'd200; THRESH1 = 12'hFFF; THRESH2 = 12'hFFF;
        MULTIPLICITY = 2'd1; COINC_WIN = 4'd0; DEADTIME = 16'd10;
        ADC0_IN = mk(2047); ADC1_IN = mk(0); ADC2_IN = mk(0);
        do_reset();
        wait_trig(20);
        seen_trig = 0; seen_busy = 0;
        step(36);
        chk("dead_trigs", 32'(seen_trig), 32'd3);
        chk("dead_busy",  32'(seen_busy), 32'd33);
        chk("dead_period_end", 32'(TRIG), 32'd1);

        // ENABLE dropped three cycles into DEAD, then re-enabled with the condition true.
        step(3);
        ENABLE = 1'b0;
        step(1);
        chk("drop_busy", 32'(BUSY), 32'd0);
        seen_trig = 0;
        step(14);
        chk("drop_no_trig", 32'(seen_trig), 32'd0);
        ENABLE = 1'b1;
        step(1);
        chk("reen_armed", 32'(TRIG), 32'd0);
        step(1);
        chk("reen_trig", 32'(TRIG), 32'd1);

        // Counter saturation with zero dead time.
        DEADTIME = 16'd0;
        do_reset();
        seen_trig = 0;
        step(40);
        chk("sat_trigs", 32'(seen_trig), 32'd20);
        chk("sat_count", 32'(TRIG_COUNT), 32'd15);
        seen_trig = 0;
        step(4);
        chk("sat_still_pulsing", 32'(seen_trig), 32'd2);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            ADC0_IN = 24'($urandom); ADC1_IN = 24'($urandom); ADC2_IN = 24'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                THRESH0 = pick_thresh(); THRESH1 = pick_thresh(); THRESH2 = pick_thresh();
                MULTIPLICITY = 2'($urandom); COINC_WIN = 4'($urandom);
                DEADTIME = 16'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 49) == 0) ENABLE = ~ENABLE;
            RESET = ($urandom_range(0, 199) == 0);
            step(1);
        end
        RESET = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
